// File: rtl/spi_regfile_pkg.sv
// Shared constants and helpers for the SPI register file and its sibling SPI blocks.
// Frame bit positions are counted from the first bit on the wire.
package spi_regfile_pkg;

    localparam int RW_BIT  = 0;
    localparam int IMM_BIT = 1;

    // Raybox default colours, 2 bits per channel.
    localparam logic [5:0] SKY_RGB_DEFAULT   = 6'b010101;
    localparam logic [5:0] FLOOR_RGB_DEFAULT = 6'b101010;

    function automatic int hdr_len(input int addr_bits);
        return 2 + addr_bits;
    endfunction

endpackage

// File: rtl/spi_sync_edge.sv
// Brings asynchronous SPI pins into the clk domain and derives SCLK edge pulses.
// Select is stored active-high so a reset (all zeros) reads as "not selected".
module spi_sync_edge (
    input  logic clk,
    input  logic reset,
    input  logic i_sclk,
    input  logic i_ss_n,
    input  logic i_mosi,
    output logic sclk_rise,
    output logic sclk_fall,
    output logic ss_active,
    output logic mosi
);

    logic [2:0] sclk_q;
    logic [1:0] ss_q;
    logic [1:0] mosi_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            sclk_q <= '0;
            ss_q   <= '0;
            mosi_q <= '0;
        end else begin
            sclk_q <= {sclk_q[1:0], i_sclk};
            ss_q   <= {ss_q[0], ~i_ss_n};
            mosi_q <= {mosi_q[0], i_mosi};
        end
    end

    assign sclk_rise = sclk_q[1] & ~sclk_q[2];
    assign sclk_fall = ~sclk_q[1] & sclk_q[2];
    assign ss_active = ss_q[1];
    assign mosi      = mosi_q[1];

endmodule

// File: rtl/spi_regfile.sv
// SPI-slave register file with live/buffered copies, immediate writes and readback.
// Buffered values become live on load_new, which the renderer pulses at frame/VBLANK.
module spi_regfile
    import spi_regfile_pkg::*;
#(
    parameter int                          NUM_REGS     = 16,
    parameter int                          REG_W        = 24,
    parameter int                          ADDR_BITS    = 6,
    parameter logic [NUM_REGS*REG_W-1:0]   RESET_VALUES = '0
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         i_sclk,
    input  logic                         i_ss_n,
    input  logic                         i_mosi,
    output logic                         o_miso,
    output logic                         o_miso_oe,
    input  logic                         load_new,
    output logic [NUM_REGS*REG_W-1:0]    regs,
    output logic [NUM_REGS-1:0]          pending,
    output logic                         wr_strobe,
    output logic [ADDR_BITS-1:0]         wr_addr
);

    localparam int HDR       = hdr_len(ADDR_BITS);
    localparam int FRAME_LEN = HDR + REG_W;
    localparam int CNT_W     = $clog2(FRAME_LEN + 1);

    logic sclk_rise, sclk_fall, ss_active, mosi;

    spi_sync_edge u_sync (
        .clk       (clk),
        .reset     (reset),
        .i_sclk    (i_sclk),
        .i_ss_n    (i_ss_n),
        .i_mosi    (i_mosi),
        .sclk_rise (sclk_rise),
        .sclk_fall (sclk_fall),
        .ss_active (ss_active),
        .mosi      (mosi)
    );

    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic [FRAME_LEN-1:0] frame_q, frame_d;
    logic                 done_q, done_d;
    logic                 hdr_done_q, hdr_done_d;
    logic [REG_W-1:0]     shift_q, shift_d;
    logic                 rd_active_q, rd_active_d;
    logic [REG_W-1:0]     live_q [NUM_REGS];
    logic [REG_W-1:0]     live_d [NUM_REGS];
    logic [REG_W-1:0]     buf_q  [NUM_REGS];
    logic [REG_W-1:0]     buf_d  [NUM_REGS];
    logic [NUM_REGS-1:0]  pend_q, pend_d;
    logic                 strobe_q, strobe_d;
    logic [ADDR_BITS-1:0] waddr_q, waddr_d;

    // The frame shifts in at the LSB: a full frame has bit 0 at the MSB, while
    // right after the header the header sits in the low HDR bits.
    logic                 f_rw, f_imm, f_addr_ok, h_rw, wr_ok;
    logic [ADDR_BITS-1:0] f_addr, h_addr;
    logic [REG_W-1:0]     f_data, rd_word;

    assign f_rw      = frame_q[FRAME_LEN-1-RW_BIT];
    assign f_imm     = frame_q[FRAME_LEN-1-IMM_BIT];
    assign f_addr    = frame_q[REG_W +: ADDR_BITS];
    assign f_data    = frame_q[REG_W-1:0];
    assign f_addr_ok = int'(f_addr) < NUM_REGS;
    assign h_rw      = frame_q[HDR-1-RW_BIT];
    assign h_addr    = frame_q[ADDR_BITS-1:0];
    assign wr_ok     = done_q & ~f_rw & f_addr_ok;

    always_comb begin
        rd_word = '0;
        for (int i = 0; i < NUM_REGS; i++) begin
            if (h_addr == ADDR_BITS'(i)) rd_word = live_q[i];
        end
    end

    always_comb begin
        cnt_d       = cnt_q;
        frame_d     = frame_q;
        done_d      = 1'b0;
        hdr_done_d  = 1'b0;
        shift_d     = shift_q;
        rd_active_d = rd_active_q;
        if (!ss_active) begin
            cnt_d       = '0;
            frame_d     = '0;
            shift_d     = '0;
            rd_active_d = 1'b0;
        end else begin
            if (sclk_rise && cnt_q != CNT_W'(FRAME_LEN)) begin
                cnt_d      = cnt_q + 1'b1;
                frame_d    = {frame_q[FRAME_LEN-2:0], mosi};
                done_d     = (cnt_q == CNT_W'(FRAME_LEN-1));
                hdr_done_d = (cnt_q == CNT_W'(HDR-1));
            end
            if (hdr_done_q && h_rw) begin
                shift_d     = rd_word;
                rd_active_d = 1'b1;
            end else if (sclk_fall && rd_active_q) begin
                shift_d = {shift_q[REG_W-2:0], 1'b0};
            end
        end
    end

    // load_new and wr_strobe are single-cycle pulses with no back-pressure. When a
    // commit meets load_new, live takes the old buffer first and the write lands after.
    always_comb begin
        live_d   = live_q;
        buf_d    = buf_q;
        pend_d   = pend_q;
        strobe_d = wr_ok;
        waddr_d  = wr_ok ? f_addr : waddr_q;
        if (load_new) begin
            live_d = buf_q;
            pend_d = '0;
        end
        for (int i = 0; i < NUM_REGS; i++) begin
            if (wr_ok && f_addr == ADDR_BITS'(i)) begin
                buf_d[i] = f_data;
                if (f_imm) begin
                    live_d[i] = f_data;
                    pend_d[i] = 1'b0;
                end else begin
                    pend_d[i] = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q       <= '0;
            frame_q     <= '0;
            done_q      <= 1'b0;
            hdr_done_q  <= 1'b0;
            shift_q     <= '0;
            rd_active_q <= 1'b0;
            pend_q      <= '0;
            strobe_q    <= 1'b0;
            waddr_q     <= '0;
            for (int i = 0; i < NUM_REGS; i++) begin
                live_q[i] <= RESET_VALUES[i*REG_W +: REG_W];
                buf_q[i]  <= RESET_VALUES[i*REG_W +: REG_W];
            end
        end else begin
            cnt_q       <= cnt_d;
            frame_q     <= frame_d;
            done_q      <= done_d;
            hdr_done_q  <= hdr_done_d;
            shift_q     <= shift_d;
            rd_active_q <= rd_active_d;
            pend_q      <= pend_d;
            strobe_q    <= strobe_d;
            waddr_q     <= waddr_d;
            live_q      <= live_d;
            buf_q       <= buf_d;
        end
    end

    for (genvar g = 0; g < NUM_REGS; g++) begin : g_regs
        assign regs[g*REG_W +: REG_W] = live_q[g];
    end

    assign pending   = pend_q;
    assign wr_strobe = strobe_q;
    assign wr_addr   = waddr_q;
    assign o_miso    = rd_active_q & shift_q[REG_W-1];
    assign o_miso_oe = ss_active;

endmodule

// File: tb/tb_spi_regfile.sv
// Randomised bench for spi_regfile: a register-level model (live/buffer arrays plus a
// queue of scheduled commits) is compared against the DUT on every clock.
module tb_spi_regfile;
    import spi_regfile_pkg::*;

    localparam int NR  = 16;
    localparam int RW  = 24;
    localparam int AB  = 6;
    localparam int HDR = 2 + AB;
    localparam int FL  = HDR + RW;
    localparam int CW  = 32 + 1 + AB + RW;

    function automatic logic [NR*RW-1:0] make_rv();
        logic [NR*RW-1:0] v;
        v = '0;
        for (int i = 0; i < NR; i++) v[i*RW +: RW] = 24'h3C0000 ^ (24'(i) * 24'h010101);
        v[0*RW +: RW] = {18'h0, SKY_RGB_DEFAULT};
        v[1*RW +: RW] = {18'h0, FLOOR_RGB_DEFAULT};
        return v;
    endfunction
    localparam logic [NR*RW-1:0] RV = make_rv();

    // ---------------- clock / reset / DUT ----------------
    logic clk = 1'b0;
    logic reset, i_sclk, i_ss_n, i_mosi, load_new;
    logic o_miso, o_miso_oe, wr_strobe;
    logic [NR*RW-1:0] regs;
    logic [NR-1:0]    pending;
    logic [AB-1:0]    wr_addr;

    always #5 clk = ~clk;

    spi_regfile #(.NUM_REGS(NR), .REG_W(RW), .ADDR_BITS(AB), .RESET_VALUES(RV)) dut (
        .clk       (clk),
        .reset     (reset),
        .i_sclk    (i_sclk),
        .i_ss_n    (i_ss_n),
        .i_mosi    (i_mosi),
        .o_miso    (o_miso),
        .o_miso_oe (o_miso_oe),
        .load_new  (load_new),
        .regs      (regs),
        .pending   (pending),
        .wr_strobe (wr_strobe),
        .wr_addr   (wr_addr)
    );

    // ---------------- scoreboard / model ----------------
    int n_cmp = 0;
    int n_fail = 0;
    int cyc = 0;
    bit chk_en = 1'b0;
    logic [CW-1:0] exp_q[$];   // {commit_cycle, imm, addr, data}
    logic [RW-1:0] m_live [NR];
    logic [RW-1:0] m_buf  [NR];
    logic [NR-1:0] m_pend;
    logic          m_strobe;
    logic [AB-1:0] m_waddr;
    logic [1:0]    m_ss;
    logic [NR*RW-1:0] exp_regs;
    int n_strobe = 0;
    logic [AB-1:0] last_waddr = '0;

    task automatic check(input string name, input logic [NR*RW-1:0] act, input logic [NR*RW-1:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    always @(posedge clk) begin
        logic [CW-1:0] e;
        cyc++;
        if (reset) begin
            for (int i = 0; i < NR; i++) begin
                m_live[i] = RV[i*RW +: RW];
                m_buf[i]  = RV[i*RW +: RW];
            end
            m_pend = '0; m_strobe = 1'b0; m_waddr = '0; m_ss = '0;
            exp_q.delete();
        end else begin
            m_ss = {m_ss[0], ~i_ss_n};
            m_strobe = 1'b0;
            if (load_new) begin
                for (int i = 0; i < NR; i++) m_live[i] = m_buf[i];
                m_pend = '0;
            end
            if (exp_q.size() > 0 && int'(exp_q[0][CW-1 -: 32]) == cyc) begin
                e = exp_q.pop_front();
                m_buf[e[RW +: AB]] = e[RW-1:0];
                if (e[RW+AB]) begin
                    m_live[e[RW +: AB]] = e[RW-1:0];
                    m_pend[e[RW +: AB]] = 1'b0;
                end else begin
                    m_pend[e[RW +: AB]] = 1'b1;
                end
                m_strobe = 1'b1;
                m_waddr = e[RW +: AB];
            end
        end
    end

    always @(negedge clk) begin
        if (wr_strobe) begin
            n_strobe++;
            last_waddr = wr_addr;
        end
        if (chk_en) begin
            for (int i = 0; i < NR; i++) exp_regs[i*RW +: RW] = m_live[i];
            check("regs", regs, exp_regs);
            check("pending", pending, m_pend);
            check("wr_strobe", wr_strobe, m_strobe);
            check("miso_oe", o_miso_oe, m_ss[1]);
            if (m_strobe) check("wr_addr", wr_addr, m_waddr);
        end
    end

    // ---------------- driver tasks ----------------
    // SCLK is 8 clk periods; MISO is taken just before each falling SCLK edge.
    task automatic spi_frame(input logic rw, input logic imm, input logic [AB-1:0] addr,
                             input logic [RW-1:0] data, input int nbits, input int extra,
                             input bit lnc, input int rst_at, output logic [RW-1:0] rdata);
        logic [FL-1:0] fr;
        int total;
        fr = {rw, imm, addr, data};
        total = (nbits == FL) ? FL + extra : nbits;
        rdata = '0;
        @(negedge clk);
        i_ss_n = 1'b0;
        repeat (4) @(negedge clk);
        for (int i = 0; i < total; i++) begin
            if (i == rst_at) begin
                reset = 1'b1;
                repeat (2) @(negedge clk);
                reset = 1'b0;
                repeat (3) @(negedge clk);
            end
            i_mosi = (i < FL) ? fr[FL-1-i] : 1'($urandom);
            repeat (4) @(negedge clk);
            i_sclk = 1'b1;
            if (i == FL-1 && nbits == FL && rst_at < 0 && !rw && int'(addr) < NR)
                exp_q.push_back({32'(cyc + 4), imm, addr, data});
            if (lnc && i == FL-1) begin
                repeat (3) @(negedge clk);
                load_new = 1'b1;
                @(negedge clk);
                load_new = 1'b0;
            end else begin
                repeat (4) @(negedge clk);
            end
            if (rw && i >= HDR-1 && i < HDR-1+RW) rdata[RW-1-(i-HDR+1)] = o_miso;
            else check("miso_idle", o_miso, 0);
            i_sclk = 1'b0;
        end
        repeat (4) @(negedge clk);
        i_ss_n = 1'b1;
        repeat (6) @(negedge clk);
    endtask

    task automatic pulse_load();
        @(negedge clk);
        load_new = 1'b1;
        @(negedge clk);
        load_new = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    function automatic logic [RW-1:0] reg_of(input int a);
        return regs[a*RW +: RW];
    endfunction

    // ---------------- stimulus ----------------
    initial begin
        logic [RW-1:0] rd, exp_rd;
        logic rw, imm;
        logic [AB-1:0] addr;
        logic [RW-1:0] data;
        int nb, ex, s0;
        bit lnc;

        reset = 1'b1; i_sclk = 1'b0; i_ss_n = 1'b1; i_mosi = 1'b0; load_new = 1'b0;
        repeat (3) @(negedge clk);
        chk_en = 1'b1;
        check("rst_regs", regs, RV);
        check("rst_pending", pending, 0);
        check("rst_strobe", wr_strobe, 0);
        check("rst_waddr", wr_addr, 0);
        check("rst_miso", o_miso, 0);
        check("rst_oe", o_miso_oe, 0);
        reset = 1'b0;
        repeat (4) @(negedge clk);

        for (int a = 0; a < NR; a++) begin
            spi_frame(1'b1, 1'b0, AB'(a), 24'(0), FL, 0, 1'b0, -1, rd);
            check("rst_readback", rd, RV[a*RW +: RW]);
        end
        check("rst_pending_after_reads", pending, 0);

        s0 = n_strobe;
        spi_frame(1'b0, 1'b0, 6'd3, 24'hABCDEF, FL, 0, 1'b0, -1, rd);
        check("buf_strobe_count", 32'(n_strobe - s0), 1);
        check("buf_waddr", last_waddr, 3);
        check("buf_pending", pending, 16'h0008);
        check("buf_live_unchanged", reg_of(3), RV[3*RW +: RW]);
        pulse_load();
        check("load_live3", reg_of(3), 24'hABCDEF);
        check("model_live3", m_live[3], 24'hABCDEF);
        check("load_pending", pending, 0);

        spi_frame(1'b0, 1'b1, 6'd7, 24'h123456, FL, 0, 1'b0, -1, rd);
        check("imm_live7", reg_of(7), 24'h123456);
        check("imm_pending", pending, 0);
        pulse_load();
        check("imm_after_load", reg_of(7), 24'h123456);

        spi_frame(1'b0, 1'b0, 6'd5, 24'h0F0F55, FL, 0, 1'b1, -1, rd);
        check("coll_live5_old", reg_of(5), RV[5*RW +: RW]);
        check("coll_pending", pending, 16'h0020);
        pulse_load();
        check("coll_live5_new", reg_of(5), 24'h0F0F55);

        s0 = n_strobe;
        spi_frame(1'b0, 1'b1, 6'd2, 24'h777777, HDR + 10, 0, 1'b0, -1, rd);
        spi_frame(1'b0, 1'b1, 6'd20, 24'h888888, FL, 0, 1'b0, -1, rd);
        check("abort_oor_no_strobe", 32'(n_strobe - s0), 0);
        check("abort_live2", reg_of(2), RV[2*RW +: RW]);
        spi_frame(1'b0, 1'b1, 6'd2, 24'h246801, FL, 0, 1'b0, -1, rd);
        check("next_frame_strobe", 32'(n_strobe - s0), 1);
        check("next_frame_live2", reg_of(2), 24'h246801);

        spi_frame(1'b1, 1'b0, 6'd3, 24'hFFFFFF, FL, 8, 1'b0, -1, rd);
        check("read3", rd, 24'hABCDEF);
        spi_frame(1'b1, 1'b0, 6'd40, 24'hFFFFFF, FL, 0, 1'b0, -1, rd);
        check("read40", rd, 24'h000000);
        s0 = n_strobe;
        spi_frame(1'b0, 1'b0, 6'd9, 24'h13579B, FL, 8, 1'b0, -1, rd);
        check("surplus_one_strobe", 32'(n_strobe - s0), 1);

        spi_frame(1'b0, 1'b1, 6'd4, 24'hDEAD01, FL, 0, 1'b0, 12, rd);
        check("midreset_regs", regs, RV);
        check("midreset_pending", pending, 0);

        for (int k = 0; k < 50; k++) begin
            rw   = ($urandom_range(0, 3) == 0);
            imm  = 1'($urandom_range(0, 1));
            addr = AB'($urandom_range(0, 19));
            data = 24'($urandom);
            nb   = ($urandom_range(0, 5) == 0) ? $urandom_range(1, FL - 1) : FL;
            ex   = ($urandom_range(0, 4) == 0) ? $urandom_range(1, 8) : 0;
            lnc  = !rw && ($urandom_range(0, 3) == 0);
            exp_rd = (int'(addr) < NR) ? m_live[addr[3:0]] : '0;
            spi_frame(rw, imm, addr, data, nb, ex, lnc, -1, rd);
            if (rw && nb == FL) check("rand_read", rd, exp_rd);
            if ($urandom_range(0, 2) == 0) pulse_load();
        end

        repeat (4) @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    initial begin
        #3000000;
        n_fail++;
        $display("FAIL watchdog: got timeout expected completion");
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
